ysyx_22040125_pc_ctrl: RTL
==========================

YSYX_22040125_PC_CTRL -- requirements
Module: ysyx_22040125_PC_CTRL

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, which is the PC fetched first after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port redirect_valid, input, 1 bit: EX-stage redirect request qualifier.
REQ-005 SHALL have port pc_sel, input, 3 bits: redirect code (see REQ-013).
REQ-006 SHALL have ports dnpc_in1 and dnpc_in2, inputs, 64 bits each: PC+imm target and (rs1+imm)&~1 target.
REQ-007 SHALL have ports mtvec and mepc, inputs, 64 bits each: trap vector and return address.
REQ-008 SHALL have ports ifu_req_valid (output, 1), ifu_req_addr (output, 64) and ifu_req_ready (input, 1): fetch request handshake.
REQ-009 SHALL have ports ifu_rsp_valid (input, 1) and ifu_rsp_inst (input, 32): fetch response, at most one per accepted request, never in the request's accept cycle.
REQ-010 SHALL have ports inst_valid (output, 1), inst (output, 32), inst_pc (output, 64) and id_ready (input, 1): instruction handoff to ID.
REQ-011 SHALL have port flush, output, 1 bit: one-cycle pulse that kills wrong-path IF/ID state.
REQ-012 SHALL have ports misalign_exc (output, 1) and misalign_addr (output, 64): instruction-address-misaligned report.

Function
REQ-013 SHALL decode pc_sel as follows: 000 = no redirect; 001 = jal to dnpc_in1; 010 = branch taken to dnpc_in1; 011 = jalr to dnpc_in2; 100 = trap to mtvec; 101 = mret to mepc; 110 and 111 = no redirect.
REQ-014 SHALL treat a redirect as taken only when redirect_valid=1 and pc_sel decodes to a target.
REQ-015 SHALL implement the states IDLE, REQ, WAIT, HOLD and DROP.
REQ-016 IDLE: SHALL move to REQ on the cycle after reset release, with pc=RESET_PC.
REQ-017 REQ: SHALL drive ifu_req_valid=1 and ifu_req_addr=pc; on ifu_req_valid&ifu_req_ready SHALL move to WAIT.
REQ-018 WAIT: SHALL keep ifu_req_valid=0; on ifu_rsp_valid SHALL capture inst and inst_pc=pc and move to HOLD.
REQ-019 HOLD: SHALL drive inst_valid=1 with inst and inst_pc stable; on id_ready SHALL set pc=pc+4 (64-bit wrap) and move to REQ.
REQ-020 SHALL keep one outstanding request at most and issue no new request before the response.
REQ-021 A taken redirect SHALL load pc with the target next cycle and pulse flush=1 in that next cycle.
REQ-022 A redirect in REQ without handshake SHALL stay in REQ at the new address; ifu_req_addr may change only on a redirect.
REQ-023 A redirect coinciding with a REQ handshake, or in WAIT without ifu_rsp_valid, SHALL move to DROP.
REQ-024 A redirect in WAIT with ifu_rsp_valid, or in HOLD, SHALL discard the instruction (inst_valid=0 next cycle) and move to REQ.
REQ-025 DROP: SHALL discard the next ifu_rsp_valid without presenting it and then move to REQ.
REQ-026 A redirect arriving while in DROP SHALL update pc and stay in DROP.
REQ-027 Redirect SHALL win over a simultaneous id_ready handshake; the held instruction is killed.
REQ-028 inst_valid SHALL never be 1 in the cycle flush=1.

Reset
REQ-029 With rst_n=0 at a clock edge, SHALL go to IDLE with pc=RESET_PC and all outputs 0 (ifu_req_valid, inst_valid, inst, inst_pc, flush, misalign_exc, misalign_addr), and drive ifu_req_addr=RESET_PC.
REQ-030 Reset mid-WAIT SHALL abandon the outstanding request; responses arriving in IDLE SHALL be ignored.

Configuration
REQ-031 With YSYX_22040125_PC_MISALIGN_TRAP_EN defined, a taken redirect with code 001/010/011 whose target[1:0]!=0 SHALL redirect to mtvec instead, pulse misalign_exc=1 for one cycle with flush, and latch misalign_addr=target.
REQ-032 Without YSYX_22040125_PC_MISALIGN_TRAP_EN, targets SHALL be used unchanged and misalign_exc and misalign_addr SHALL be tied to 0.

Verification
REQ-033 Reset release, ready always 1, response 1 cycle later, id_ready=1 -> requests at 0x80000000, 0x80000004, 0x80000008; no flush.
REQ-034 In HOLD with pc=0x80000010, redirect pc_sel=010 with dnpc_in1=0x80000100 and id_ready=1 -> flush pulse, held inst not consumed, next request at 0x80000100.
REQ-035 Redirect pc_sel=011 with dnpc_in2=0x80000200 during WAIT, response 3 cycles later -> DROP; response discarded (inst_valid stays 0); next request at 0x80000200.
REQ-036 pc_sel=000, 110 or 111 with redirect_valid=1 -> no flush and sequential fetch unchanged; pc_sel=101 with mepc=0x80001000 -> next request at 0x80001000.
REQ-037 With the macro defined, pc_sel=001 with dnpc_in1=0x80000102 and mtvec=0x80000800 -> misalign_exc=1 for 1 cycle, misalign_addr=0x80000102, next request at 0x80000800; without the macro -> next request at 0x80000102 and misalign_exc=0.
REQ-038 rst_n=0 for 1 cycle mid-WAIT, followed by a stale response in IDLE -> stale response ignored; first request at RESET_PC.

Source files
------------

// File: rtl/ysyx_22040125_pc_ctrl.sv
// PC control and instruction fetch sequencer: one outstanding fetch, EX redirects.
// Optional misaligned-target trap: define YSYX_22040125_PC_MISALIGN_TRAP_EN.
module ysyx_22040125_pc_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [2:0]  pc_sel,
    input  logic [63:0] dnpc_in1,
    input  logic [63:0] dnpc_in2,
    input  logic [63:0] mtvec,
    input  logic [63:0] mepc,
    output logic        ifu_req_valid,
    output logic [63:0] ifu_req_addr,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        id_ready,
    output logic        flush,
    output logic        misalign_exc,
    output logic [63:0] misalign_addr
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [63:0] pc_q;
    logic [63:0] pc_d;
    logic [31:0] inst_q;
    logic [31:0] inst_d;
    logic [63:0] inst_pc_q;
    logic [63:0] inst_pc_d;
    logic        flush_q;
    logic        flush_d;

    logic        sel_hit;
    logic        sel_ctl;
    logic [63:0] sel_tgt;
    logic        take;
    logic [63:0] tgt;
    logic        bad_tgt;

    logic        req_fire;

    // Redirect code decode: which codes carry a target and where it points
    always_comb begin
        sel_hit = 1'b0;
        sel_ctl = 1'b0;
        sel_tgt = 64'd0;
        unique case (1'b1)
            (pc_sel == 3'b001),
            (pc_sel == 3'b010): begin
                sel_hit = 1'b1;
                sel_ctl = 1'b1;
                sel_tgt = dnpc_in1;
            end
            (pc_sel == 3'b011): begin
                sel_hit = 1'b1;
                sel_ctl = 1'b1;
                sel_tgt = dnpc_in2;
            end
            (pc_sel == 3'b100): begin
                sel_hit = 1'b1;
                sel_tgt = mtvec;
            end
            (pc_sel == 3'b101): begin
                sel_hit = 1'b1;
                sel_tgt = mepc;
            end
            default: begin
                sel_hit = 1'b0;
            end
        endcase
    end

    assign take = redirect_valid & sel_hit;

`ifdef YSYX_22040125_PC_MISALIGN_TRAP_EN
    logic        mexc_q;
    logic        mexc_d;
    logic [63:0] maddr_q;
    logic [63:0] maddr_d;

    // Control-transfer targets off a 4-byte boundary are diverted to mtvec
    always_comb begin
        bad_tgt = take & sel_ctl & (sel_tgt[1:0] != 2'b00);
        tgt     = bad_tgt ? mtvec : sel_tgt;
    end

    // Misalign report: one-cycle pulse, address held until the next report
    always_comb begin
        mexc_d  = 1'b0;
        maddr_d = maddr_q;
        if (bad_tgt && state_q != S_IDLE) begin
            mexc_d  = 1'b1;
            maddr_d = sel_tgt;
        end
    end

    // Misalign report registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mexc_q  <= 1'b0;
            maddr_q <= 64'd0;
        end else begin
            mexc_q  <= mexc_d;
            maddr_q <= maddr_d;
        end
    end

    assign misalign_exc  = mexc_q;
    assign misalign_addr = maddr_q;
`else
    // Targets are used as given; the ctl flag has no consumer here
    always_comb begin
        bad_tgt = 1'b0;
        tgt     = sel_tgt;
    end

    assign misalign_exc  = 1'b0;
    assign misalign_addr = 64'd0;

    logic unused_ok;
    assign unused_ok = sel_ctl ^ bad_tgt;
`endif

    assign req_fire = (state_q == S_REQ) & ifu_req_ready;

    // Next-state, next-PC and handoff capture
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        flush_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                pc_d    = RESET_PC;
            end
            S_REQ: begin
                if (take) begin
                    pc_d    = tgt;
                    flush_d = 1'b1;
                    state_d = req_fire ? S_DROP : S_REQ;
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (take) begin
                    pc_d    = tgt;
                    flush_d = 1'b1;
                    state_d = ifu_rsp_valid ? S_REQ : S_DROP;
                end else if (ifu_rsp_valid) begin
                    inst_d    = ifu_rsp_inst;
                    inst_pc_d = pc_q;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (take) begin
                    pc_d    = tgt;
                    flush_d = 1'b1;
                    state_d = S_REQ;
                end else if (id_ready) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (take) begin
                    pc_d    = tgt;
                    flush_d = 1'b1;
                end
                // A response here belongs to a killed request
                if (ifu_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = RESET_PC;
            end
        endcase
    end

    // State, PC and handoff registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            inst_pc_q <= 64'd0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            flush_q   <= flush_d;
        end
    end

    assign ifu_req_valid = (state_q == S_REQ);
    assign ifu_req_addr  = pc_q;
    assign inst_valid    = (state_q == S_HOLD);
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign flush         = flush_q;

endmodule
